// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider: restoring radix-2, one quotient bit per cycle,
// valid/ready on both sides, RNE/RTZ rounding, FTZ and IEEE exception flags.
module fp_div_iter #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] input_a,
    input  logic [EXP_W+MAN_W:0] input_b,
    input  logic                 rnd_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [4:0]           flags
);

    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned EW    = EXP_W + 2;
    localparam int unsigned QW    = MAN_W + 3;
    localparam int unsigned RW    = MAN_W + 2;
    localparam int unsigned CNT_W = $clog2(QW);

    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(QW - 1);
    localparam logic signed [EW-1:0] BIAS_S    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX_S    = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_S     = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S    = EW'(0);
    localparam logic [EXP_W-1:0]     EXP_ONES  = '1;
    localparam logic [EXP_W-1:0]     EXP_MAXF  = EXP_ONES - EXP_W'(1);
    localparam logic [W-1:0]         QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [4:0] FLG_NV = 5'b10000;
    localparam logic [4:0] FLG_DZ = 5'b01000;
    localparam logic [4:0] FLG_OF = 5'b00101;
    localparam logic [4:0] FLG_UF = 5'b00011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic w_accept;
    logic w_calc_en;
    logic w_load_res;
    logic w_in_ready_nxt;
    logic w_out_valid_nxt;

    // operand registers captured at accept
    logic [EXP_W-1:0] r_ea;
    logic [EXP_W-1:0] r_eb;
    logic             r_sign;
    logic             r_rtz;
    logic             r_spec;
    logic [W-1:0]     r_spec_res;
    logic [4:0]       r_spec_flg;
    logic [RW-1:0]    r_rem;
    logic [MAN_W:0]   r_div;
    logic [QW-1:0]    r_q;
    logic [CNT_W-1:0] r_cnt;

    logic             r_in_ready;
    logic             r_out_valid;
    logic [W-1:0]     r_result;
    logic [4:0]       r_flags;

    // operand decode; subnormals are treated as zero
    logic [EXP_W-1:0] w_a_exp;
    logic [EXP_W-1:0] w_b_exp;
    logic [MAN_W-1:0] w_a_frac;
    logic [MAN_W-1:0] w_b_frac;
    logic w_a_zero, w_a_emax, w_a_nan, w_a_snan, w_a_inf;
    logic w_b_zero, w_b_emax, w_b_nan, w_b_snan, w_b_inf;
    logic w_sign_in;

    assign w_a_exp   = input_a[W-2:MAN_W];
    assign w_b_exp   = input_b[W-2:MAN_W];
    assign w_a_frac  = input_a[MAN_W-1:0];
    assign w_b_frac  = input_b[MAN_W-1:0];
    assign w_sign_in = input_a[W-1] ^ input_b[W-1];

    assign w_a_zero = (w_a_exp == '0);
    assign w_a_emax = (w_a_exp == EXP_ONES);
    assign w_a_nan  = w_a_emax & (|w_a_frac);
    assign w_a_snan = w_a_nan & ~w_a_frac[MAN_W-1];
    assign w_a_inf  = w_a_emax & ~(|w_a_frac);

    assign w_b_zero = (w_b_exp == '0);
    assign w_b_emax = (w_b_exp == EXP_ONES);
    assign w_b_nan  = w_b_emax & (|w_b_frac);
    assign w_b_snan = w_b_nan & ~w_b_frac[MAN_W-1];
    assign w_b_inf  = w_b_emax & ~(|w_b_frac);

    // special-case result, in priority order
    logic         w_spec;
    logic [W-1:0] w_spec_res;
    logic [4:0]   w_spec_flg;

    always_comb begin
        w_spec     = 1'b1;
        w_spec_res = QNAN;
        w_spec_flg = '0;
        if (w_a_nan || w_b_nan) begin
            w_spec_flg = (w_a_snan || w_b_snan) ? FLG_NV : 5'b00000;
        end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_flg = FLG_NV;
        end else if (w_b_zero && !w_a_inf) begin
            w_spec_res = {w_sign_in, EXP_ONES, {MAN_W{1'b0}}};
            w_spec_flg = FLG_DZ;
        end else if (w_a_inf) begin
            w_spec_res = {w_sign_in, EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_b_inf || w_a_zero) begin
            w_spec_res = {w_sign_in, {(W-1){1'b0}}};
        end else begin
            w_spec = 1'b0;
        end
    end

    // one restoring step
    logic          w_ge;
    logic [RW-1:0] w_diff;
    logic [RW-1:0] w_rem_nxt;

    assign w_ge      = (r_rem >= {1'b0, r_div});
    assign w_diff    = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;
    assign w_rem_nxt = w_diff << 1;

    // normalise and round; below-one quotients fold R into sticky
    logic                 w_qint;
    logic [MAN_W:0]       w_mant;
    logic                 w_g;
    logic                 w_rs;
    logic                 w_up;
    logic [RW-1:0]        w_mant_rnd;
    logic                 w_carry;
    logic [MAN_W-1:0]     w_frac;
    logic                 w_inexact;
    logic signed [EW-1:0] w_exp_pre;
    logic signed [EW-1:0] w_exp_fin;

    assign w_qint     = r_q[QW-1];
    assign w_mant     = w_qint ? r_q[QW-1:2] : r_q[QW-2:1];
    assign w_g        = w_qint ? r_q[1] : r_q[0];
    assign w_rs       = w_qint ? (r_q[0] | (|r_rem)) : (|r_rem);
    assign w_up       = ~r_rtz & w_g & (w_rs | w_mant[0]);
    assign w_mant_rnd = {1'b0, w_mant} + RW'(w_up);
    assign w_carry    = w_mant_rnd[RW-1];
    assign w_frac     = w_carry ? w_mant_rnd[MAN_W:1] : w_mant_rnd[MAN_W-1:0];
    assign w_inexact  = w_g | w_rs;

    assign w_exp_pre = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb}) + BIAS_S
                       - (w_qint ? ZERO_S : ONE_S);
    assign w_exp_fin = w_exp_pre + (w_carry ? ONE_S : ZERO_S);

    logic [W-1:0] w_res_rnd;
    logic [4:0]   w_flg_rnd;

    always_comb begin
        w_res_rnd = {r_sign, w_exp_fin[EXP_W-1:0], w_frac};
        w_flg_rnd = {4'b0000, w_inexact};
        if (r_spec) begin
            w_res_rnd = r_spec_res;
            w_flg_rnd = r_spec_flg;
        end else if (w_exp_fin >= EMAX_S) begin
            w_res_rnd = r_rtz ? {r_sign, EXP_MAXF, {MAN_W{1'b1}}}
                              : {r_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_flg_rnd = FLG_OF;
        end else if (w_exp_fin < ONE_S) begin
            w_res_rnd = {r_sign, {(W-1){1'b0}}};
            w_flg_rnd = FLG_UF;
        end
    end

    // state register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_calc_en   = 1'b0;
        w_load_res  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_calc_en = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                w_load_res  = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
    end

    // operand capture and divide iterations
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_ea       <= '0;
            r_eb       <= '0;
            r_sign     <= 1'b0;
            r_rtz      <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_res <= '0;
            r_spec_flg <= '0;
            r_rem      <= '0;
            r_div      <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_ea       <= w_a_exp;
            r_eb       <= w_b_exp;
            r_sign     <= w_sign_in;
            r_rtz      <= rnd_mode;
            r_spec     <= w_spec;
            r_spec_res <= w_spec_res;
            r_spec_flg <= w_spec_flg;
            r_rem      <= {2'b01, w_a_frac};
            r_div      <= {1'b1, w_b_frac};
            r_q        <= '0;
            r_cnt      <= '0;
        end else if (w_calc_en) begin
            r_rem <= w_rem_nxt;
            r_q   <= {r_q[QW-2:0], w_ge};
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // registered outputs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            if (w_load_res) begin
                r_result <= w_res_rnd;
                r_flags  <= w_flg_rnd;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard bench for fp_div_iter: FP32 directed vectors, handshake, reset
// abort and a small FP16 instance.
module tb_fp_div_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  flags;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [15:0] in_a16 = '0;
    logic [15:0] in_b16 = '0;
    logic        mode16 = 1'b0;
    logic        out_valid16;
    logic        out_ready16 = 1'b1;
    logic [15:0] result16;
    logic [4:0]  flags16;

    fp_div_iter #(.EXP_W(8), .MAN_W(23)) u_dut32 (
        .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .input_a(in_a), .input_b(in_b), .rnd_mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fp_div_iter #(.EXP_W(5), .MAN_W(10)) u_dut16 (
        .Clk(clk), .Rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .input_a(in_a16), .input_b(in_b16), .rnd_mode(mode16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16), .flags(flags16)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          acc;
        int          id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   op_id = 0;
    logic ov_q = 1'b0;

    // output side of the scoreboard: latency on rise, compare on handshake
    always @(negedge clk) begin
        if (rst) begin
            ov_q = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("sb_entry", 64'(sb.size()), 64'd1);
                end else begin
                    if (!ov_q)
                        check($sformatf("lat%0d", sb[0].id), 64'(cyc - sb[0].acc), 64'd27);
                    if (out_ready) begin
                        mon_e = sb.pop_front();
                        check($sformatf("res%0d", mon_e.id), 64'(result), 64'(mon_e.res));
                        check($sformatf("flg%0d", mon_e.id), 64'(flags), 64'(mon_e.flg));
                    end
                end
            end
            ov_q = out_valid;
        end
    end

    // drive one operation, push its expectation at the accepting edge
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic m,
                        input logic [31:0] er, input logic [4:0] ef, output int acc);
        bit   ok;
        exp_t e;
        ok  = 1'b0;
        acc = 0;
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        mode     = m;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc   = cyc;
                e.res = er;
                e.flg = ef;
                e.acc = cyc;
                e.id  = op_id;
                op_id++;
                sb.push_back(e);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check("accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic m,
                          input logic [15:0] er, input logic [4:0] ef);
        int acc16;
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        in_a16     = a;
        in_b16     = b;
        mode16     = m;
        in_valid16 = 1'b1;
        check("rdy16", 64'(in_ready16), 64'd1);
        @(posedge clk);
        #1;
        acc16      = cyc;
        in_valid16 = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (out_valid16) seen = 1'b1;
        end
        check("ov16", 64'(seen), 64'd1);
        check("lat16", 64'(cyc - acc16), 64'd14);
        check("res16", 64'(result16), 64'(er));
        check("flg16", 64'(flags16), 64'(ef));
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        m;
        logic [31:0] r;
        logic [4:0]  f;
    } vec_t;

    localparam int NOPS = 19;
    vec_t vecs [NOPS] = '{
        '{32'h40C00000, 32'h3FC00000, 1'b0, 32'h40800000, 5'b00000},
        '{32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAB, 5'b00001},
        '{32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAA, 5'b00001},
        '{32'h3F800000, 32'h00000000, 1'b0, 32'h7F800000, 5'b01000},
        '{32'h00000000, 32'h00000000, 1'b0, 32'h7FC00000, 5'b10000},
        '{32'h7F800000, 32'h40000000, 1'b0, 32'h7F800000, 5'b00000},
        '{32'h7F7FFFFF, 32'h3F000000, 1'b0, 32'h7F800000, 5'b00101},
        '{32'h7F7FFFFF, 32'h3F000000, 1'b1, 32'h7F7FFFFF, 5'b00101},
        '{32'h00800000, 32'h40000000, 1'b0, 32'h00000000, 5'b00011},
        '{32'h40000000, 32'h40400000, 1'b0, 32'h3F2AAAAB, 5'b00001},
        '{32'hC0C00000, 32'h3FC00000, 1'b0, 32'hC0800000, 5'b00000},
        '{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b10000},
        '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b00000},
        '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 5'b10000},
        '{32'hBF800000, 32'h7F800000, 1'b0, 32'h80000000, 5'b00000},
        '{32'h00000001, 32'h3F800000, 1'b0, 32'h00000000, 5'b00000},
        '{32'h3F800000, 32'h00000001, 1'b0, 32'h7F800000, 5'b01000},
        '{32'h7F800000, 32'h00000000, 1'b0, 32'h7F800000, 5'b00000},
        '{32'h40000000, 32'h40800000, 1'b0, 32'h3F000000, 5'b00000}
    };

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_a;
        int acc_b;
        bit seen;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_in_ready16", 64'(in_ready16), 64'd1);
        rst = 1'b0;

        for (int i = 0; i < NOPS; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].r, vecs[i].f, acc_a);
            in_valid = 1'b0;
            wait_drain();
        end

        // consumer stall: output held, input side closed
        out_ready = 1'b0;
        send(32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAB, 5'b00001, acc_a);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("stall_ov", 64'(seen), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_res", 64'(result), 64'h3EAAAAAB);
            check("stall_rdy", 64'(in_ready), 64'd0);
            check("stall_ov", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_release", 64'(in_ready), 64'd1);
        check("stall_popped", 64'(sb.size()), 64'd0);

        // back-to-back: second request waits for IDLE, first operands unaffected
        send(32'h40C00000, 32'h3FC00000, 1'b0, 32'h40800000, 5'b00000, acc_a);
        @(negedge clk);
        check("b2b_busy", 64'(in_ready), 64'd0);
        send(32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAA, 5'b00001, acc_b);
        in_valid = 1'b0;
        check("b2b_gap", 64'(acc_b - acc_a), 64'd29);
        wait_drain();

        // reset mid-divide aborts
        send(32'h40C00000, 32'h3FC00000, 1'b0, 32'h40800000, 5'b00000, acc_a);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_result", 64'(out_valid), 64'd0);
        send(32'h40C00000, 32'h3FC00000, 1'b0, 32'h40800000, 5'b00000, acc_a);
        in_valid = 1'b0;
        wait_drain();

        // half precision instance
        send16(16'h4600, 16'h3E00, 1'b0, 16'h4400, 5'b00000);
        send16(16'h3C00, 16'h4200, 1'b0, 16'h3555, 5'b00001);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_div_iter.md
Name: fp_div_iter

Overview:
- Parametrised iterative IEEE-754 floating-point divider.
- Successor to the fixed FP32 FloatingDivision block, which has only Clk, Rst, operands and result.
- Adds: generic exponent/mantissa width, a valid/ready handshake on both sides, a selectable rounding mode, and IEEE exception flags.
- Used as the divide unit in the multi-precision FP datapath: one instance per lane, instantiated at FP32, FP16 or narrower.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width. Total word width W = 1+EXP_W+MAN_W.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- input_a  in  W  dividend.
- input_b  in  W  divisor.
- rnd_mode  in  1  0 = round-nearest-even (RNE), 1 = round-toward-zero (RTZ). Sampled at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  quotient.
- flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}. Valid with out_valid.

Behaviour:
- Reset (async, Rst=1): state=IDLE, in_ready=1, out_valid=0, result=0, flags=0. Internal registers cleared. Rst asserted mid-divide aborts the operation; no result is produced.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, register operands and rnd_mode, go to CALC with iteration count=0.
  - CALC: restoring radix-2 division, one quotient bit per cycle, MAN_W+3 cycles. Inputs are 1.f dividend/divisor. Sticky = OR of the final remainder.
  - ROUND: normalise, round, pack, and set flags. Go to DONE.
  - DONE: out_valid=1. result and flags held stable until out_ready. On out_valid&&out_ready go to IDLE.
- in_ready=0 in all states other than IDLE. No same-cycle accept on the DONE→IDLE edge.
- Latency: out_valid rises exactly MAN_W+4 rising edges after the accepting edge (27 for FP32, 14 for FP16).
  - Latency is fixed for all operands, including special cases, which are decoded at accept and forced in ROUND.
- Arithmetic:
  - sign = sa^sb.
  - Exponent computed in EXP_W+2 signed bits: e = ea-eb+BIAS, minus 1 when the quotient is <1 (1-bit left normalise).
  - Round uses guard, round and sticky bits.
  - RNE: round up when G&&(R||S||lsb).
  - RTZ: truncate.
  - A mantissa carry-out after rounding increments the exponent.
- Subnormal inputs are flushed to signed zero before decode (FTZ).
- Subnormal or zero results from finite nonzero operands flush to signed zero and set underflow and inexact.
- Overflow (e ≥ all-ones):
  - RNE → ±inf.
  - RTZ → ±max finite.
  - Both modes set overflow and inexact.
- inexact = G|R|S, unless the result is a special-case result.
- Special cases, in priority order:
  1. Any NaN operand → canonical qNaN (sign 0, exponent all-ones, fraction MSB 1, rest 0). invalid is set only for signalling NaN.
  2. 0/0 or inf/inf → canonical qNaN, invalid.
  3. finite nonzero/0 → ±inf, div_by_zero.
  4. inf/finite → ±inf, no flags.
  5. finite/inf and 0/nonzero → ±0, no flags.
- Operands and input signals are ignored while in_ready=0. out_ready is ignored while out_valid=0.

Test Plan:
- FP32, RNE: 0x40C00000 / 0x3FC00000 (6.0/1.5) → result=0x40800000, flags=0, out_valid rises 27 cycles after accept.
- FP32 1/3 (0x3F800000 / 0x40400000): RNE → 0x3EAAAAAB, flags=00001. RTZ → 0x3EAAAAAA, flags=00001.
- FP32 special cases:
  - 0x3F800000 / 0x00000000 → 0x7F800000, flags=01000.
  - 0x00000000 / 0x00000000 → 0x7FC00000, flags=10000.
  - 0x7F800000 / 0x40000000 → 0x7F800000, flags=0.
- FP32 range limits:
  - 0x7F7FFFFF / 0x3F000000: RNE → 0x7F800000, flags=00101. RTZ → 0x7F7FFFFF, flags=00101.
  - 0x00800000 / 0x40000000 → 0x00000000, flags=00011.
- Handshake:
  - Hold out_ready=0 for 10 cycles; result stays stable and in_ready stays 0.
  - Release out_ready; in_ready rises the next cycle.
  - Back-to-back in_valid is accepted only from IDLE.
- Reset and FP16:
  - Assert Rst mid-CALC → out_valid=0 and in_ready=1 immediately. The next operation completes correctly.
  - EXP_W=5, MAN_W=10 instance: 0x4600 / 0x3E00 → 0x4400 after 14 cycles.
